// File: rtl/fpmul_stage4_pack.sv
// fpmul_stage4_pack: last stage of the four-stage single-precision multiplier.
// Renormalises the rounded significand, applies exception overrides, packs the
// IEEE-754 word and hands it downstream via a valid/ready interface backed by
// an output register plus one skid register.
// Optional feature macro: FPMUL_STICKY_FLAGS_EN builds the sticky exception
// flags; without it the flag outputs are tied low and flags_clr is ignored.
module fpmul_stage4_pack #(
  parameter int          SIG_width   = 28,
  parameter logic [31:0] NAN_PATTERN = 32'h7FC00000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [7:0]           EXP_in,
  input  logic [SIG_width-1:0] SIG_in,
  input  logic                 SIGN_in,
  input  logic                 EXP_pos_in,
  input  logic                 EXP_neg_in,
  input  logic                 isINF_in,
  input  logic                 isNaN_in,
  input  logic                 isZ_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          FP_Z,
  input  logic                 flags_clr,
  output logic                 flag_ov,
  output logic                 flag_uf,
  output logic                 flag_nv,
  output logic                 flag_nx
);

  logic                 carryBit;
  logic [SIG_width-1:0] sigNorm;
  logic [8:0]           exp9;
  logic                 ovCond;
  logic                 ufCond;
  logic                 nxCond;
  logic                 specialCase;
  logic [31:0]          packedWord;

  logic                 accept;
  logic                 drain;

  logic [31:0]          fpZ_q, fpZ_d;
  logic                 outValid_q, outValid_d;
  logic [31:0]          skid_q, skid_d;
  logic                 skidFull_q, skidFull_d;

  logic                 unusedBits;

  // Renormalise after rounding, derive exception conditions and pack the word.
  always_comb begin
    carryBit    = SIG_in[SIG_width-1];
    sigNorm     = carryBit ? (SIG_in >> 1) : SIG_in;
    exp9        = {1'b0, EXP_in} + {8'd0, carryBit};
    ovCond      = EXP_pos_in | (exp9 >= 9'd255);
    ufCond      = EXP_neg_in | (exp9 == 9'd0);
    nxCond      = (|sigNorm[SIG_width-26:0]) | (carryBit & SIG_in[0]);
    specialCase = isNaN_in | isINF_in | isZ_in;
    if (isNaN_in) begin
      packedWord = NAN_PATTERN;
    end else if (isINF_in) begin
      packedWord = {SIGN_in, 8'hFF, 23'h0};
    end else if (isZ_in) begin
      packedWord = {SIGN_in, 31'h0};
    end else if (ovCond) begin
      packedWord = {SIGN_in, 8'hFF, 23'h0};
    end else if (ufCond) begin
      packedWord = {SIGN_in, 31'h0};
    end else begin
      packedWord = {SIGN_in, exp9[7:0], sigNorm[SIG_width-3 -: 23]};
    end
  end

  assign in_ready  = ~skidFull_q;
  assign out_valid = outValid_q;
  assign FP_Z      = fpZ_q;
  assign accept    = in_valid & ~skidFull_q;
  assign drain     = outValid_q & out_ready;

  // Next state of the output/skid pair: FIFO order, skid refills the output on drain.
  always_comb begin
    fpZ_d      = fpZ_q;
    outValid_d = outValid_q;
    skid_d     = skid_q;
    skidFull_d = skidFull_q;
    if (drain) begin
      if (skidFull_q) begin
        fpZ_d      = skid_q;
        skidFull_d = 1'b0;
      end else if (accept) begin
        fpZ_d = packedWord;
      end else begin
        outValid_d = 1'b0;
      end
    end else if (accept) begin
      if (!outValid_q) begin
        fpZ_d      = packedWord;
        outValid_d = 1'b1;
      end else begin
        skid_d     = packedWord;
        skidFull_d = 1'b1;
      end
    end
  end

  // Output and skid registers; reset discards any beats in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fpZ_q      <= 32'h0;
      outValid_q <= 1'b0;
      skid_q     <= 32'h0;
      skidFull_q <= 1'b0;
    end else begin
      fpZ_q      <= fpZ_d;
      outValid_q <= outValid_d;
      skid_q     <= skid_d;
      skidFull_q <= skidFull_d;
    end
  end

`ifdef FPMUL_STICKY_FLAGS_EN
  logic flagOv_q, flagOv_d;
  logic flagUf_q, flagUf_d;
  logic flagNv_q, flagNv_d;
  logic flagNx_q, flagNx_d;
  logic setOv, setUf, setNv, setNx;

  // Sticky flag next state: a set event in the same cycle wins over a clear.
  always_comb begin
    setNv    = accept & isNaN_in;
    setOv    = accept & ~specialCase & ovCond;
    setUf    = accept & ~specialCase & ufCond;
    setNx    = accept & ~specialCase & nxCond;
    flagOv_d = (flagOv_q & ~flags_clr) | setOv;
    flagUf_d = (flagUf_q & ~flags_clr) | setUf;
    flagNv_d = (flagNv_q & ~flags_clr) | setNv;
    flagNx_d = (flagNx_q & ~flags_clr) | setNx;
  end

  // Sticky flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flagOv_q <= 1'b0;
      flagUf_q <= 1'b0;
      flagNv_q <= 1'b0;
      flagNx_q <= 1'b0;
    end else begin
      flagOv_q <= flagOv_d;
      flagUf_q <= flagUf_d;
      flagNv_q <= flagNv_d;
      flagNx_q <= flagNx_d;
    end
  end

  assign flag_ov    = flagOv_q;
  assign flag_uf    = flagUf_q;
  assign flag_nv    = flagNv_q;
  assign flag_nx    = flagNx_q;
  assign unusedBits = &{1'b0, sigNorm[SIG_width-1:SIG_width-2]};
`else
  assign flag_ov    = 1'b0;
  assign flag_uf    = 1'b0;
  assign flag_nv    = 1'b0;
  assign flag_nx    = 1'b0;
  assign unusedBits = &{1'b0, sigNorm[SIG_width-1:SIG_width-2], flags_clr, nxCond, specialCase};
`endif

endmodule

// File: tb/tb_fpmul_stage4_pack.sv
// Self-checking bench for fpmul_stage4_pack: directed cases plus randomized
// traffic compared against a queue-based reference model of the packer.
module tb_fpmul_stage4_pack;

  typedef struct {
    logic [7:0]  e;
    logic [27:0] sig;
    logic        sign;
    logic        pos;
    logic        neg;
    logic        inf;
    logic        nan;
    logic        z;
  } beat_t;

`ifdef FPMUL_STICKY_FLAGS_EN
  localparam bit FLAGS_ON = 1'b1;
`else
  localparam bit FLAGS_ON = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  EXP_in;
  logic [27:0] SIG_in;
  logic        SIGN_in;
  logic        EXP_pos_in;
  logic        EXP_neg_in;
  logic        isINF_in;
  logic        isNaN_in;
  logic        isZ_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] FP_Z;
  logic        flags_clr;
  logic        flag_ov;
  logic        flag_uf;
  logic        flag_nv;
  logic        flag_nx;

  int checkCount = 0;
  int errorCount = 0;

  logic [31:0] expQ[$];
  bit mOv, mUf, mNv, mNx;

  fpmul_stage4_pack dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .EXP_in     (EXP_in),
    .SIG_in     (SIG_in),
    .SIGN_in    (SIGN_in),
    .EXP_pos_in (EXP_pos_in),
    .EXP_neg_in (EXP_neg_in),
    .isINF_in   (isINF_in),
    .isNaN_in   (isNaN_in),
    .isZ_in     (isZ_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .FP_Z       (FP_Z),
    .flags_clr  (flags_clr),
    .flag_ov    (flag_ov),
    .flag_uf    (flag_uf),
    .flag_nv    (flag_nv),
    .flag_nx    (flag_nx)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expected value and log mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Reference packer computed with plain integer arithmetic from the IEEE rules.
  function automatic void refPack(input beat_t b, output logic [31:0] w,
                                  output bit ov, output bit uf, output bit nx);
    int unsigned sigv, carry, s, ex;
    sigv  = b.sig;
    carry = sigv / (1 << 27);
    s     = (carry == 1) ? sigv / 2 : sigv;
    ex    = b.e + carry;
    ov    = b.pos || (ex >= 255);
    uf    = b.neg || (ex == 0);
    nx    = ((s % 8) != 0) || ((carry == 1) && ((sigv % 2) == 1));
    if (b.nan)      w = 32'h7FC00000;
    else if (b.inf) w = b.sign ? 32'hFF800000 : 32'h7F800000;
    else if (b.z)   w = b.sign ? 32'h80000000 : 32'h00000000;
    else if (ov)    w = b.sign ? 32'hFF800000 : 32'h7F800000;
    else if (uf)    w = b.sign ? 32'h80000000 : 32'h00000000;
    else            w = (b.sign ? 32'h80000000 : 32'h0) + (32'(ex) * 32'h800000) + ((s / 8) % 32'h800000);
  endfunction

  // Drive one cycle's worth of inputs.
  task automatic applyStimulus(input bit vld, input beat_t b, input bit rdy, input bit clr);
    in_valid   = vld;
    EXP_in     = b.e;
    SIG_in     = b.sig;
    SIGN_in    = b.sign;
    EXP_pos_in = b.pos;
    EXP_neg_in = b.neg;
    isINF_in   = b.inf;
    isNaN_in   = b.nan;
    isZ_in     = b.z;
    out_ready  = rdy;
    flags_clr  = clr;
  endtask

  // Advance one clock, update the reference model, then check every output.
  task automatic clockAndCheck(output bit accepted);
    beat_t       b;
    logic [31:0] w;
    bit          ov, uf, nx, drn, special;
    b = '{EXP_in, SIG_in, SIGN_in, EXP_pos_in, EXP_neg_in, isINF_in, isNaN_in, isZ_in};
    refPack(b, w, ov, uf, nx);
    accepted = in_valid && (expQ.size() < 2);
    drn      = out_ready && (expQ.size() > 0);
    special  = b.nan || b.inf || b.z;
    @(posedge clk);
    #1;
    if (drn) void'(expQ.pop_front());
    if (accepted) expQ.push_back(w);
    mNv = (mNv && !flags_clr) || (accepted && b.nan);
    mOv = (mOv && !flags_clr) || (accepted && !special && ov);
    mUf = (mUf && !flags_clr) || (accepted && !special && uf);
    mNx = (mNx && !flags_clr) || (accepted && !special && nx);
    checkOutput("out_valid", {31'b0, out_valid}, {31'b0, expQ.size() > 0});
    checkOutput("in_ready", {31'b0, in_ready}, {31'b0, expQ.size() < 2});
    if (expQ.size() > 0) checkOutput("FP_Z", FP_Z, expQ[0]);
    checkOutput("flag_ov", {31'b0, flag_ov}, {31'b0, FLAGS_ON && mOv});
    checkOutput("flag_uf", {31'b0, flag_uf}, {31'b0, FLAGS_ON && mUf});
    checkOutput("flag_nv", {31'b0, flag_nv}, {31'b0, FLAGS_ON && mNv});
    checkOutput("flag_nx", {31'b0, flag_nx}, {31'b0, FLAGS_ON && mNx});
  endtask

  function automatic beat_t mkBeat(input logic [7:0] e, input logic [27:0] sig, input logic sign);
    beat_t b;
    b = '{e, sig, sign, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    return b;
  endfunction

  // Check the reset state of every output, no clock edge involved.
  task automatic checkResetState(input string tag);
    checkOutput({tag, "_out_valid"}, {31'b0, out_valid}, 32'd0);
    checkOutput({tag, "_in_ready"}, {31'b0, in_ready}, 32'd1);
    checkOutput({tag, "_FP_Z"}, FP_Z, 32'd0);
    checkOutput({tag, "_flags"}, {28'b0, flag_ov, flag_uf, flag_nv, flag_nx}, 32'd0);
  endtask

  initial begin
    beat_t b;
    beat_t abc[3];
    bit    acc;
    int    idx;

    rst_n = 1'b0;
    applyStimulus(1'b0, mkBeat(8'h0, 28'h0, 1'b0), 1'b1, 1'b0);
    #12;
    checkResetState("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Normal product 2.0
    applyStimulus(1'b1, mkBeat(8'h80, 28'h4000000, 1'b0), 1'b1, 1'b0);
    clockAndCheck(acc);
    checkOutput("normal_word", FP_Z, 32'h40000000);
    applyStimulus(1'b0, mkBeat(8'h0, 28'h0, 1'b0), 1'b1, 1'b0);
    clockAndCheck(acc);

    // Renormalisation carry
    applyStimulus(1'b1, mkBeat(8'h7F, 28'h8000000, 1'b1), 1'b1, 1'b0);
    clockAndCheck(acc);
    checkOutput("renorm_word", FP_Z, 32'hC0000000);

    // Overflow through the carry, then a lone clear
    applyStimulus(1'b1, mkBeat(8'hFE, 28'h8000000, 1'b0), 1'b1, 1'b0);
    clockAndCheck(acc);
    checkOutput("ovf_word", FP_Z, 32'h7F800000);
    checkOutput("ovf_flag", {31'b0, flag_ov}, {31'b0, FLAGS_ON});
    applyStimulus(1'b0, mkBeat(8'h0, 28'h0, 1'b0), 1'b1, 1'b1);
    clockAndCheck(acc);
    checkOutput("ovf_clr", {31'b0, flag_ov}, 32'd0);

    // NaN beats zero; then forced underflow
    b = mkBeat(8'h40, 28'h4000000, 1'b0);
    b.nan = 1'b1;
    b.z   = 1'b1;
    applyStimulus(1'b1, b, 1'b1, 1'b0);
    clockAndCheck(acc);
    checkOutput("nan_word", FP_Z, 32'h7FC00000);
    checkOutput("nan_flag", {31'b0, flag_nv}, {31'b0, FLAGS_ON});
    b = mkBeat(8'h40, 28'h4000000, 1'b1);
    b.neg = 1'b1;
    applyStimulus(1'b1, b, 1'b1, 1'b0);
    clockAndCheck(acc);
    checkOutput("uf_word", FP_Z, 32'h80000000);
    checkOutput("uf_flag", {31'b0, flag_uf}, {31'b0, FLAGS_ON});
    applyStimulus(1'b0, mkBeat(8'h0, 28'h0, 1'b0), 1'b1, 1'b1);
    clockAndCheck(acc);

    // Back-pressure with three beats A, B, C
    abc[0] = mkBeat(8'h81, 28'h4000008, 1'b0);
    abc[1] = mkBeat(8'h82, 28'h5800000, 1'b1);
    abc[2] = mkBeat(8'h83, 28'h7FFFFF8, 1'b0);
    idx = 0;
    for (int c = 0; c < 5; c++) begin
      applyStimulus(idx < 3, abc[idx < 3 ? idx : 2], 1'b0, 1'b0);
      clockAndCheck(acc);
      if (acc) idx++;
    end
    checkOutput("bp_accepted", idx, 2);
    for (int c = 0; c < 12 && (idx < 3 || expQ.size() > 0); c++) begin
      applyStimulus(idx < 3, abc[idx < 3 ? idx : 2], 1'b1, 1'b0);
      clockAndCheck(acc);
      if (acc) idx++;
    end
    checkOutput("bp_drained", {31'b0, expQ.size() == 0 && idx == 3}, 32'd1);

    // Asynchronous reset with the skid full and flags set
    b = mkBeat(8'h10, 28'h4000001, 1'b0);
    b.nan = 1'b1;
    for (int c = 0; c < 3; c++) begin
      applyStimulus(1'b1, b, 1'b0, 1'b0);
      clockAndCheck(acc);
    end
    applyStimulus(1'b0, b, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    checkResetState("async");
    expQ.delete();
    mOv = 0; mUf = 0; mNv = 0; mNx = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized traffic
    for (int c = 0; c < 400; c++) begin
      b.e    = 8'($urandom);
      case ($urandom_range(0, 5))
        0: b.e = 8'h00;
        1: b.e = 8'hFE;
        2: b.e = 8'hFF;
        default: ;
      endcase
      b.sig  = 28'($urandom);
      b.sign = 1'($urandom);
      b.pos  = ($urandom_range(0, 19) == 0);
      b.neg  = ($urandom_range(0, 19) == 0);
      b.inf  = ($urandom_range(0, 15) == 0);
      b.nan  = ($urandom_range(0, 15) == 0);
      b.z    = ($urandom_range(0, 15) == 0);
      applyStimulus($urandom_range(0, 9) < 7, b, $urandom_range(0, 9) < 6,
                    $urandom_range(0, 9) == 0);
      clockAndCheck(acc);
    end

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
